// File: rtl/nibble_packer.sv
// Pairs tagged low/high nibbles into bytes behind a valid/ready handshake,
// flags out-of-order nibbles and counts delivered bytes.
module nibble_packer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic [3:0] nib_i,
   input  logic       nib_sel,
   input  logic       nib_valid,
   output logic       nib_ready,
   output logic [7:0] byte_o,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       seq_err,
   output logic [7:0] byte_count
);

   localparam int unsigned NIB_W  = 4;
   localparam int unsigned BYTE_W = 8;

   localparam logic [1:0] WAIT_LO = 2'd0;
   localparam logic [1:0] WAIT_HI = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;

   logic [1:0]        state, state_nx;
   logic [NIB_W-1:0]  lo_reg, lo_nx;
   logic [BYTE_W-1:0] byte_nx, count_nx;
   logic              err_nx, ready_nx, valid_nx;
   logic              nib_acc, byte_acc;

   assign nib_acc  = nib_valid && nib_ready;
   assign byte_acc = byte_valid && byte_ready;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= WAIT_LO;
         lo_reg     <= '0;
         byte_o     <= '0;
         seq_err    <= 1'b0;
         byte_count <= '0;
         nib_ready  <= 1'b1;
         byte_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         lo_reg     <= lo_nx;
         byte_o     <= byte_nx;
         seq_err    <= err_nx;
         byte_count <= count_nx;
         nib_ready  <= ready_nx;
         byte_valid <= valid_nx;
      end
   end

   // Next-state and next-output logic; flush overrides every handshake
   always_comb begin
      state_nx = state;
      lo_nx    = lo_reg;
      byte_nx  = byte_o;
      count_nx = byte_count;
      err_nx   = 1'b0;

      if (flush) begin
         state_nx = WAIT_LO;
      end else begin
         case (state)
            WAIT_LO: begin
               if (nib_acc) begin
                  if (!nib_sel) begin
                     lo_nx    = nib_i;
                     state_nx = WAIT_HI;
                  end else begin
                     err_nx = 1'b1;
                  end
               end
            end
            WAIT_HI: begin
               if (nib_acc) begin
                  if (nib_sel) begin
                     byte_nx  = {nib_i, lo_reg};
                     state_nx = HOLD;
                  end else begin
                     lo_nx  = nib_i;
                     err_nx = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (byte_acc) begin
                  count_nx = byte_count + BYTE_W'(1);
                  state_nx = WAIT_LO;
               end
            end
            default: state_nx = WAIT_LO;
         endcase
      end

      // Handshake flags are pure functions of the upcoming state
      ready_nx = (state_nx != HOLD);
      valid_nx = (state_nx == HOLD);
   end

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: a byte-level reference model predicts
// each assembled byte, and a monitor checks handshake outputs every cycle.
module tb_nibble_packer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic [3:0] nib_i = 4'h0;
   logic       nib_sel = 1'b0;
   logic       nib_valid = 1'b0;
   logic       nib_ready;
   logic [7:0] byte_o;
   logic       byte_valid;
   logic       byte_ready = 1'b0;
   logic       seq_err;
   logic [7:0] byte_count;

   nibble_packer dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .nib_i(nib_i), .nib_sel(nib_sel), .nib_valid(nib_valid), .nib_ready(nib_ready),
      .byte_o(byte_o), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .seq_err(seq_err), .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: an optional pending low nibble, an optional held byte
   bit         m_have_lo = 1'b0;
   bit         m_holding = 1'b0;
   bit         m_err     = 1'b0;
   logic [3:0] m_lo      = 4'h0;
   int         m_cnt     = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_have_lo = 1'b0;
      m_holding = 1'b0;
      m_err     = 1'b0;
      m_cnt     = 0;
      exp_q.delete();
   endtask

   // Model advances on each rising edge from the stable TB-driven inputs
   always @(posedge clk) begin
      if (rst_n) begin
         m_err = 1'b0;
         if (flush) begin
            if (m_holding && exp_q.size() > 0) void'(exp_q.pop_back());
            m_holding = 1'b0;
            m_have_lo = 1'b0;
         end else if (m_holding) begin
            if (byte_ready) begin
               m_holding = 1'b0;
               m_cnt     = (m_cnt + 1) % 256;
            end
         end else if (nib_valid) begin
            if (!m_have_lo) begin
               if (nib_sel) m_err = 1'b1;
               else begin m_lo = nib_i; m_have_lo = 1'b1; end
            end else if (nib_sel) begin
               exp_q.push_back({nib_i, m_lo});
               m_holding = 1'b1;
               m_have_lo = 1'b0;
            end else begin
               m_lo  = nib_i;
               m_err = 1'b1;
            end
         end
      end
   end

   // Monitor: compare outputs mid-cycle and retire bytes that will be delivered
   always @(negedge clk) begin
      chk("nib_ready", 32'(nib_ready), 32'(!m_holding));
      chk("byte_valid", 32'(byte_valid), 32'(m_holding));
      chk("seq_err", 32'(seq_err), 32'(m_err));
      chk("byte_count", 32'(byte_count), 32'(m_cnt));
      if (byte_valid) begin
         if (exp_q.size() == 0) begin
            chk("byte_unexpected", 32'(byte_o), 32'hFFFF_FFFF);
         end else begin
            chk("byte_o", 32'(byte_o), 32'(exp_q[0]));
            if (byte_ready && !flush && rst_n) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step(input bit v, input bit s, input logic [3:0] d, input bit br, input bit fl);
      nib_valid  = v;
      nib_sel    = s;
      nib_i      = d;
      byte_ready = br;
      flush      = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      step(1'b1, 1'b0, b[3:0], 1'b1, 1'b0);
      step(1'b1, 1'b1, b[7:4], 1'b1, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_nib_ready", 32'(nib_ready), 32'd1);
      chk("rst_byte_valid", 32'(byte_valid), 32'd0);
      chk("rst_byte_o", 32'(byte_o), 32'h00);
      chk("rst_byte_count", 32'(byte_count), 32'h00);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

      // Basic pair
      send_byte(8'h5A);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("basic_count", 32'(byte_count), 32'd1);

      // Backpressure with the next low nibble already offered
      step(1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("stall_byte_o", 32'(byte_o), 32'h3C);
      step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
      chk("bp_second_byte", 32'(byte_o), 32'hF0);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("bp_count", 32'(byte_count), 32'd3);

      // Sequence errors
      step(1'b1, 1'b1, 4'h7, 1'b1, 1'b0);
      step(1'b1, 1'b0, 4'h1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 4'h2, 1'b1, 1'b0);
      step(1'b1, 1'b1, 4'h9, 1'b1, 1'b0);
      chk("seq_byte", 32'(byte_o), 32'h92);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

      // Flush mid-pair with a simultaneous high nibble, then flush in HOLD
      step(1'b1, 1'b0, 4'hE, 1'b1, 1'b0);
      step(1'b1, 1'b1, 4'hD, 1'b1, 1'b1);
      step(1'b1, 1'b1, 4'h4, 1'b1, 1'b0);
      step(1'b1, 1'b0, 4'h6, 1'b1, 1'b0);
      step(1'b1, 1'b1, 4'h8, 1'b1, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("flush_count", 32'(byte_count), 32'd4);

      // Async reset between edges while holding a byte
      step(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'hC, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_byte_valid", 32'(byte_valid), 32'd0);
      chk("arst_byte_count", 32'(byte_count), 32'd0);
      chk("arst_byte_o", 32'(byte_o), 32'h00);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

      // 256 deliveries wrap the count back to zero
      for (int i = 0; i < 256; i++) send_byte(8'(i));
      chk("wrap_count", 32'(byte_count), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         step(($urandom % 4) != 0, 1'($urandom), 4'($urandom),
              ($urandom % 3) != 0, ($urandom % 40) == 0);
      end
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
